// File: rtl/lsu_mem_master.sv
// Load/store unit: data-memory initiator with alignment/funct3 checking,
// store lane replication and load sign/zero extension after MEM_LAT cycles.
module lsu_mem_master #(
   parameter int unsigned AW      = 12,
   parameter int unsigned MEM_LAT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid,
   input  logic          i_ld,
   input  logic          i_sw,
   input  logic [2:0]    i_funct3,
   input  logic [31:0]   i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_ready,
   output logic          o_done,
   output logic [31:0]   o_rdata,
   output logic          o_misalign,
   output logic          o_illegal,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_mem_wdata,
   output logic [3:0]    o_mem_wmask,
   output logic          o_mem_ld,
   output logic          o_mem_sw,
   input  logic [31:0]   i_mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [2:0] CNT_INIT = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

   state_t          state_q, state_d;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic            ld_q;
   logic            illegal_q, misalign_q;
   logic [AW-1:0]   mem_addr_q;
   logic [31:0]     mem_wdata_q;
   logic [3:0]      mask_q;
   logic [2:0]      cnt_q;
   logic [31:0]     rdata_q;

   logic            accept, capture;
   logic            illegal_d, misalign_d, fault_d;
   logic [31:0]     wdata_fmt, load_fmt, lane_word;
   logic [3:0]      mask_fmt;

   logic            unused_addr_hi;
   assign unused_addr_hi = ^i_addr[31:AW+2];

   // Request decode; illegal masks misalign so only one flag is raised
   always_comb begin
      illegal_d  = (i_ld == i_sw)
                 || (i_sw && !(i_funct3 inside {3'b000, 3'b001, 3'b010}))
                 || (i_ld && !(i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
      misalign_d = !illegal_d
                 && (((i_funct3 == 3'b001 || i_funct3 == 3'b101) && i_addr[0])
                     || (i_funct3 == 3'b010 && i_addr[1:0] != 2'b00));
      fault_d    = illegal_d | misalign_d;
   end

   always_comb begin
      wdata_fmt = i_wdata;
      mask_fmt  = 4'b1111;
      case (i_funct3[1:0])
         2'b00: begin
            wdata_fmt = {4{i_wdata[7:0]}};
            mask_fmt  = 4'b0001 << i_addr[1:0];
         end
         2'b01: begin
            wdata_fmt = {2{i_wdata[15:0]}};
            mask_fmt  = 4'b0011 << i_addr[1:0];
         end
         default: begin
            wdata_fmt = i_wdata;
            mask_fmt  = 4'b1111;
         end
      endcase
   end

   always_comb begin
      lane_word = i_mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_fmt = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b001:  load_fmt = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b100:  load_fmt = {24'd0, lane_word[7:0]};
         3'b101:  load_fmt = {16'd0, lane_word[15:0]};
         default: load_fmt = i_mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      o_ready     = 1'b0;
      o_done      = 1'b0;
      o_mem_ld    = 1'b0;
      o_mem_sw    = 1'b0;
      o_mem_wmask = '0;
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               accept  = 1'b1;
               state_d = fault_d ? DONE : REQ;
            end
         end
         REQ: begin
            if (!ld_q) begin
               o_mem_sw    = 1'b1;
               o_mem_wmask = mask_q;
               state_d     = DONE;
            end else begin
               o_mem_ld = 1'b1;
               if (MEM_LAT == 0) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait counter is preloaded at accept so it is already MEM_LAT-1 on WAIT entry
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         f3_q        <= '0;
         off_q       <= '0;
         ld_q        <= 1'b0;
         illegal_q   <= 1'b0;
         misalign_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mask_q      <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            f3_q        <= i_funct3;
            off_q       <= i_addr[1:0];
            ld_q        <= i_ld;
            illegal_q   <= illegal_d;
            misalign_q  <= misalign_d;
            mem_addr_q  <= i_addr[AW+1:2];
            mem_wdata_q <= wdata_fmt;
            mask_q      <= mask_fmt;
            cnt_q       <= CNT_INIT;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (capture) begin
            rdata_q <= load_fmt;
         end
      end
   end

   assign o_rdata     = rdata_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_misalign  = (state_q == DONE) && misalign_q;
   assign o_illegal   = (state_q == DONE) && illegal_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: three instances (MEM_LAT 0, 2, 3) share stimulus and
// are checked each cycle against a transaction-level model plus literal expectations.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid, i_ld, i_sw;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_wdata;

   logic [2:0]  ready_a, done_a, mis_a, ill_a, mld_a, msw_a;
   logic [31:0] rdata_a [3];
   logic [31:0] mwd_a   [3];
   logic [31:0] mrd_a   [3];
   logic [11:0] maddr_a [3];
   logic [3:0]  mask_a  [3];

   logic [31:0] mem [3][64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned L = (k == 0) ? 0 : k + 1;
      lsu_mem_master #(.AW(12), .MEM_LAT(L)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .i_valid     (i_valid),
         .i_ld        (i_ld),
         .i_sw        (i_sw),
         .i_funct3    (i_funct3),
         .i_addr      (i_addr),
         .i_wdata     (i_wdata),
         .o_ready     (ready_a[k]),
         .o_done      (done_a[k]),
         .o_rdata     (rdata_a[k]),
         .o_misalign  (mis_a[k]),
         .o_illegal   (ill_a[k]),
         .o_mem_addr  (maddr_a[k]),
         .o_mem_wdata (mwd_a[k]),
         .o_mem_wmask (mask_a[k]),
         .o_mem_ld    (mld_a[k]),
         .o_mem_sw    (msw_a[k]),
         .i_mem_rdata (mrd_a[k])
      );
      // Memory returns data only in the cycle it is due; other cycles read as garbage
      if (L == 0) begin : g_async
         assign mrd_a[k] = mld_a[k] ? mem[k][maddr_a[k][5:0]] : 32'hDEADBEEF;
      end else begin : g_pipe
         logic [7:0] pv = '0;
         logic [5:0] pa [8];
         always @(posedge clk) begin
            pv    <= {pv[6:0], mld_a[k]};
            pa[0] <= maddr_a[k][5:0];
            for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
         end
         assign mrd_a[k] = pv[L-1] ? mem[k][pa[L-1]] : 32'hDEADBEEF;
      end
   end

   // ---------------- transaction-level model ----------------
   function automatic logic [1:0] classify(input logic ld, input logic sw,
                                           input logic [2:0] f3, input logic [31:0] a);
      logic ill, mis;
      ill = (ld == sw) || (sw && f3 > 3'd2) || (ld && !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5));
      mis = 1'b0;
      if (!ill) begin
         if (f3 == 3'd1 || f3 == 3'd5) mis = (a % 2) != 0;
         if (f3 == 3'd2)               mis = (a % 4) != 0;
      end
      return {ill, mis};
   endfunction

   function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] s;
      s = w >> (int'(off) * 8);
      case (f3)
         3'd0:    return 32'($signed(s[7:0]));
         3'd1:    return 32'($signed(s[15:0]));
         3'd4:    return 32'(s[7:0]);
         3'd5:    return 32'(s[15:0]);
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [1:0] off);
      int unsigned sz;
      sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] st_rep(input logic [2:0] f3, input logic [31:0] wd);
      if (f3 == 3'd0) return {4{wd[7:0]}};
      if (f3 == 3'd1) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] rep);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = rep[8*b +: 8];
      return r;
   endfunction

   int unsigned m_e [3];
   int unsigned m_tot [3];
   logic        m_live [3] = '{1'b0, 1'b0, 1'b0};
   logic        m_isld [3], m_isst [3], m_ill [3], m_mis [3];
   logic [3:0]  m_mask [3];
   logic [31:0] m_wd [3], m_rd [3], m_pend [3];
   logic [11:0] m_addr [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            m_e[k]    <= 0;
            m_rd[k]   <= '0;
            m_live[k] <= 1'b1;
         end else if (m_e[k] != 0) begin
            if (m_e[k] == m_tot[k]) m_e[k] <= 0;
            else begin
               m_e[k] <= m_e[k] + 1;
               if (m_e[k] + 1 == m_tot[k] && m_isld[k]) m_rd[k] <= m_pend[k];
            end
         end else if (i_valid) begin
            logic [1:0]  f;
            int unsigned lat;
            f   = classify(i_ld, i_sw, i_funct3, i_addr);
            lat = (k == 0) ? 0 : k + 1;
            m_ill[k]  <= f[1];
            m_mis[k]  <= f[0];
            m_isld[k] <= (f == 2'b00) && i_ld;
            m_isst[k] <= (f == 2'b00) && i_sw;
            m_addr[k] <= 12'(i_addr / 4);
            m_mask[k] <= st_mask(i_funct3, i_addr[1:0]);
            m_wd[k]   <= st_rep(i_funct3, i_wdata);
            m_pend[k] <= ld_fmt(mem[k][i_addr[7:2]], i_funct3, i_addr[1:0]);
            m_e[k]    <= 1;
            m_tot[k]  <= (f != 2'b00) ? 1 : i_sw ? 2 : 2 + lat;
            if (f == 2'b00 && i_sw)
               mem[k][i_addr[7:2]] <= st_merge(mem[k][i_addr[7:2]], st_mask(i_funct3, i_addr[1:0]),
                                               st_rep(i_funct3, i_wdata));
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (m_live[k]) begin
            logic dn, rl, rs;
            dn = (m_e[k] != 0) && (m_e[k] == m_tot[k]);
            rl = (m_e[k] == 1) && m_isld[k];
            rs = (m_e[k] == 1) && m_isst[k];
            chk($sformatf("ready[%0d]", k),    32'(ready_a[k]), 32'(m_e[k] == 0));
            chk($sformatf("done[%0d]", k),     32'(done_a[k]),  32'(dn));
            chk($sformatf("misalign[%0d]", k), 32'(mis_a[k]),   32'(dn && m_mis[k]));
            chk($sformatf("illegal[%0d]", k),  32'(ill_a[k]),   32'(dn && m_ill[k]));
            chk($sformatf("mem_ld[%0d]", k),   32'(mld_a[k]),   32'(rl));
            chk($sformatf("mem_sw[%0d]", k),   32'(msw_a[k]),   32'(rs));
            chk($sformatf("wmask[%0d]", k),    32'(mask_a[k]),  32'(rs ? m_mask[k] : 4'b0000));
            chk($sformatf("rdata[%0d]", k),    rdata_a[k],      m_rd[k]);
            if (rs) chk($sformatf("mem_wdata[%0d]", k), mwd_a[k], m_wd[k]);
            if (rs || (m_isld[k] && m_e[k] != 0 && m_e[k] < m_tot[k]))
               chk($sformatf("mem_addr[%0d]", k), 32'(maddr_a[k]), 32'(m_addr[k]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ready_a != 3'b111 && n < 60) begin
         tick();
         n++;
      end
      if (ready_a != 3'b111) chk("idle_timeout", 32'(ready_a), 32'h7);
   endtask

   task automatic setreq(input logic ld, input logic sw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      i_ld = ld; i_sw = sw; i_funct3 = f3; i_addr = a; i_wdata = wd;
   endtask

   task automatic issue(input logic ld, input logic sw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      wait_idle();
      setreq(ld, sw, f3, a, wd);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic preload(input int unsigned idx, input logic [31:0] w);
      wait_idle();
      for (int k = 0; k < 3; k++) mem[k][idx] = w;
   endtask

   initial begin
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 64; i++) mem[k][i] = 32'(i) * 32'h01030507 ^ 32'h5A000000;
      reset = 1'b0; i_valid = 1'b0;
      setreq(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) tick();
      reset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(ready_a[k]), 32'd1);
         chk("rst_done", 32'(done_a[k]), 32'd0);
         chk("rst_addr", 32'(maddr_a[k]), 32'd0);
         chk("rst_wdata", mwd_a[k], 32'd0);
         chk("rst_rdata", rdata_a[k], 32'd0);
         chk("rst_mask", 32'(mask_a[k]), 32'd0);
      end

      // SB 0x103
      issue(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5);
      @(negedge clk);
      chk("sb_sw", 32'(msw_a[0]), 32'd1);
      chk("sb_addr", 32'(maddr_a[0]), 32'h040);
      chk("sb_mask", 32'(mask_a[0]), 32'b1000);
      chk("sb_wdata", mwd_a[0], 32'hA5A5A5A5);
      @(negedge clk);
      chk("sb_done", 32'(done_a[0]), 32'd1);

      // Sign/zero-extended loads
      preload(0, 32'h00800000);
      issue(1'b1, 1'b0, 3'd0, 32'h002, 32'd0);
      @(negedge clk); @(negedge clk);
      chk("lb_done", 32'(done_a[0]), 32'd1);
      chk("lb_rdata", rdata_a[0], 32'hFFFFFF80);
      issue(1'b1, 1'b0, 3'd4, 32'h002, 32'd0);
      @(negedge clk); @(negedge clk);
      chk("lbu_rdata", rdata_a[0], 32'h00000080);
      preload(0, 32'h80010000);
      issue(1'b1, 1'b0, 3'd5, 32'h002, 32'd0);
      wait_idle();
      for (int k = 0; k < 3; k++) chk("lhu_rdata", rdata_a[k], 32'h00008001);

      // Faults
      issue(1'b1, 1'b0, 3'd2, 32'h006, 32'd0);
      @(negedge clk);
      chk("lw_mis_done", 32'(done_a[0]), 32'd1);
      chk("lw_mis_flag", 32'(mis_a[0]), 32'd1);
      chk("lw_mis_ld", 32'(mld_a[0]), 32'd0);
      chk("lw_mis_rdata", rdata_a[0], 32'h00008001);
      issue(1'b1, 1'b0, 3'd3, 32'h000, 32'd0);
      @(negedge clk);
      chk("f3_011_ill", 32'(ill_a[0]), 32'd1);
      issue(1'b1, 1'b1, 3'd2, 32'h000, 32'd0);
      @(negedge clk);
      chk("ldsw_ill", 32'(ill_a[0]), 32'd1);
      chk("ldsw_mis", 32'(mis_a[0]), 32'd0);

      // MEM_LAT=2 timing, with ignored i_valid pulses
      preload(4, 32'h12345678);
      issue(1'b1, 1'b0, 3'd2, 32'h010, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         setreq(1'b0, 1'b1, 3'd2, 32'h010, 32'hFFFFFFFF);
         i_valid = (c != 3);
         @(negedge clk);
         chk("lat2_ld", 32'(mld_a[1]), 32'(c == 1));
         chk("lat2_done", 32'(done_a[1]), 32'(c == 4));
         chk("lat2_busy", 32'(ready_a[1]), 32'd0);
         if (c == 4) chk("lat2_rdata", rdata_a[1], 32'h12345678);
         tick();
      end
      i_valid = 1'b0;
      issue(1'b1, 1'b0, 3'd2, 32'h010, 32'd0);
      wait_idle();
      chk("lat0_took_pulse", rdata_a[0], 32'hFFFFFFFF);
      chk("lat2_ignored", rdata_a[1], 32'h12345678);
      chk("lat3_ignored", rdata_a[2], 32'h12345678);

      // Reset held two cycles while the MEM_LAT=3 instance waits
      issue(1'b1, 1'b0, 3'd2, 32'h010, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("rstw_done", 32'(done_a[2]), 32'd0);
      chk("rstw_ld", 32'(mld_a[2]), 32'd0);
      chk("rstw_rdata", rdata_a[2], 32'd0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rstw_ready", 32'(ready_a[2]), 32'd1);
      chk("rstw_addr", 32'(maddr_a[2]), 32'd0);
      chk("rstw_wdata", mwd_a[2], 32'd0);
      chk("rstw_mask", 32'(mask_a[2]), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rstw_no_done", 32'(done_a[2]), 32'd0);
      end

      // Back-to-back SW then LW with i_valid held
      wait_idle();
      setreq(1'b0, 1'b1, 3'd2, 32'h020, 32'hCAFEF00D);
      i_valid = 1'b1;
      tick();
      setreq(1'b1, 1'b0, 3'd2, 32'h020, 32'd0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("b2b_ready", 32'(ready_a[0]), 32'(c == 3));
         if (c == 2) chk("b2b_sw_done", 32'(done_a[0]), 32'd1);
         tick();
      end
      i_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ld", 32'(mld_a[0]), 32'd1);
      chk("b2b_addr", 32'(maddr_a[0]), 32'h008);
      @(negedge clk);
      chk("b2b_done", 32'(done_a[0]), 32'd1);
      chk("b2b_rdata", rdata_a[0], 32'hCAFEF00D);
      wait_idle();
      chk("b2b_rdata1", rdata_a[1], 32'hCAFEF00D);
      chk("b2b_rdata2", rdata_a[2], 32'hCAFEF00D);

      // Further lane/format vectors, checked by the model
      issue(1'b0, 1'b1, 3'd1, 32'h022, 32'h1234BEEF);
      issue(1'b1, 1'b0, 3'd1, 32'h022, 32'd0);
      issue(1'b1, 1'b0, 3'd0, 32'h021, 32'd0);
      issue(1'b1, 1'b0, 3'd5, 32'h020, 32'd0);
      issue(1'b0, 1'b1, 3'd0, 32'h023, 32'h0000017F);
      issue(1'b1, 1'b0, 3'd2, 32'h020, 32'd0);
      issue(1'b1, 1'b0, 3'd0, 32'h023, 32'd0);
      issue(1'b0, 1'b1, 3'd4, 32'h020, 32'd0);
      issue(1'b0, 1'b1, 3'd1, 32'h021, 32'd0);
      issue(1'b1, 1'b0, 3'd1, 32'h023, 32'd0);
      issue(1'b1, 1'b0, 3'd5, 32'h021, 32'd0);
      issue(1'b0, 1'b0, 3'd2, 32'h020, 32'd0);
      issue(1'b1, 1'b0, 3'd6, 32'h020, 32'd0);
      issue(1'b1, 1'b0, 3'd4, 32'h03F, 32'd0);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
